// File: rtl/regdst_pkg.sv
// Shared definitions for the register-destination tracker: select codes,
// default parameter values and the in-flight stage entry.
package regdst_pkg;

    // Destination select codes
    localparam int unsigned SEL_RT = 0;
    localparam int unsigned SEL_RD = 1;
    localparam int unsigned SEL_SP = 2;
    localparam int unsigned SEL_RA = 3;
    localparam int unsigned SEL_RS = 4;

    // Default parameter values
    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_SEL_W    = 3;
    localparam int unsigned DEF_DEPTH    = 3;
    localparam int unsigned DEF_CONST_SP = 29;
    localparam int unsigned DEF_CONST_RA = 31;

    // Stage entries carry the destination at this fixed width; ADDR_W must not exceed it
    localparam int unsigned MAX_ADDR_W = 16;

    // One in-flight tracking stage
    typedef struct packed {
        logic [MAX_ADDR_W-1:0] dst;
        logic                  v;
    } stage_t;

endpackage

// File: rtl/regdst_decode.sv
// Combinational destination-register select mux.
// Unknown select codes fall back to the rt field.
module regdst_decode
    import regdst_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned SEL_W    = DEF_SEL_W,
    parameter int unsigned CONST_SP = DEF_CONST_SP,
    parameter int unsigned CONST_RA = DEF_CONST_RA
) (
    input  logic [SEL_W-1:0]  sel,
    input  logic [ADDR_W-1:0] f20_16,
    input  logic [ADDR_W-1:0] f15_11,
    input  logic [ADDR_W-1:0] f25_21,
    output logic [ADDR_W-1:0] dst_sel
);

    // Select the write destination from instruction fields or constants
    always_comb begin
        dst_sel = f20_16;
        case (sel)
            SEL_W'(SEL_RT): dst_sel = f20_16;
            SEL_W'(SEL_RD): dst_sel = f15_11;
            SEL_W'(SEL_SP): dst_sel = ADDR_W'(CONST_SP);
            SEL_W'(SEL_RA): dst_sel = ADDR_W'(CONST_RA);
            SEL_W'(SEL_RS): dst_sel = f25_21;
            default:        dst_sel = f20_16;
        endcase
    end

endmodule

// File: rtl/regdst_tracker.sv
// Register-destination tracker: decodes the write destination, tracks it
// through DEPTH in-flight stages, flags source hazards / stall, and retires
// the destination to the register-file write port DEPTH+1 edges after issue.
// Optional build macro REGDST_FWD_EN adds fwd_a/fwd_b forwarding indices and
// restricts stall to matches whose youngest hit is in stage 0.
module regdst_tracker
    import regdst_pkg::*;
#(
    parameter  int unsigned ADDR_W   = DEF_ADDR_W,
    parameter  int unsigned SEL_W    = DEF_SEL_W,
    parameter  int unsigned DEPTH    = DEF_DEPTH,
    parameter  int unsigned CONST_SP = DEF_CONST_SP,
    parameter  int unsigned CONST_RA = DEF_CONST_RA,
    localparam int unsigned FWD_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [SEL_W-1:0]  sel,
    input  logic [ADDR_W-1:0] f20_16,
    input  logic [ADDR_W-1:0] f15_11,
    input  logic [ADDR_W-1:0] f25_21,
    input  logic              issue,
    input  logic              wr_en,
    input  logic              advance,
    input  logic              flush,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    output logic [ADDR_W-1:0] dst_sel,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic              stall,
`ifdef REGDST_FWD_EN
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
`endif
    output logic [ADDR_W-1:0] ret_dst,
    output logic              ret_valid
);

    stage_t                stg [DEPTH];
    logic [MAX_ADDR_W-1:0] src_a_w;
    logic [MAX_ADDR_W-1:0] src_b_w;
    logic                  wr_valid;

    assign src_a_w = MAX_ADDR_W'(src_a);
    assign src_b_w = MAX_ADDR_W'(src_b);

    // Destination decode
    regdst_decode #(
        .ADDR_W  (ADDR_W),
        .SEL_W   (SEL_W),
        .CONST_SP(CONST_SP),
        .CONST_RA(CONST_RA)
    ) u_decode (
        .sel    (sel),
        .f20_16 (f20_16),
        .f15_11 (f15_11),
        .f25_21 (f25_21),
        .dst_sel(dst_sel)
    );

    // Compare sources against valid pre-edge stage contents; r0 never hazards
    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (stg[k].v && (stg[k].dst == src_a_w) && (src_a != '0)) begin
                hazard_a = 1'b1;
            end
            if (stg[k].v && (stg[k].dst == src_b_w) && (src_b != '0)) begin
                hazard_b = 1'b1;
            end
        end
    end

`ifdef REGDST_FWD_EN
    // Youngest matching stage (1-based); scanning old-to-young lets the youngest win
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (stg[k].v && (stg[k].dst == src_a_w) && (src_a != '0)) begin
                fwd_a = FWD_W'(k + 1);
            end
            if (stg[k].v && (stg[k].dst == src_b_w) && (src_b != '0)) begin
                fwd_b = FWD_W'(k + 1);
            end
        end
    end

    // Only a stage-0 producer cannot be forwarded in time
    always_comb begin
        stall = issue & ((fwd_a == FWD_W'(1)) | (fwd_b == FWD_W'(1)));
    end
`else
    // Any pending match blocks issue
    always_comb begin
        stall = issue & (hazard_a | hazard_b);
    end
`endif

    // A stalled, non-writing or r0-targeting issue enters as a bubble
    assign wr_valid = issue & wr_en & ~stall & (dst_sel != '0);

    // Stage shift pipeline and retire register; flush beats advance and issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stg[k] <= '0;
            end
            ret_dst   <= '0;
            ret_valid <= 1'b0;
        end else if (flush) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stg[k].v <= 1'b0;
            end
            ret_valid <= 1'b0;
        end else if (advance) begin
            stg[0].dst <= MAX_ADDR_W'(dst_sel);
            stg[0].v   <= wr_valid;
            for (int k = 1; k < int'(DEPTH); k++) begin
                stg[k] <= stg[k-1];
            end
            ret_dst   <= ADDR_W'(stg[DEPTH-1].dst);
            ret_valid <= stg[DEPTH-1].v;
        end
    end

endmodule

// File: tb/tb_regdst_tracker.sv
// Directed self-checking bench for regdst_tracker (DEPTH=3, default widths).
// Retire expectations come from a scoreboard of accepted issues tagged with
// the advance-edge count at which each should appear on ret_dst.
module tb_regdst_tracker;

    localparam int unsigned DEPTH = 3;
`ifdef REGDST_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] sel = '0;
    logic [4:0] f20_16 = '0;
    logic [4:0] f15_11 = '0;
    logic [4:0] f25_21 = '0;
    logic       issue = 1'b0;
    logic       wr_en = 1'b0;
    logic       advance = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] src_a = '0;
    logic [4:0] src_b = '0;
    logic [4:0] dst_sel;
    logic       hazard_a;
    logic       hazard_b;
    logic       stall;
`ifdef REGDST_FWD_EN
    logic [2:0] fwd_a;
    logic [2:0] fwd_b;
`endif
    logic [4:0] ret_dst;
    logic       ret_valid;

    regdst_tracker dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sel      (sel),
        .f20_16   (f20_16),
        .f15_11   (f15_11),
        .f25_21   (f25_21),
        .issue    (issue),
        .wr_en    (wr_en),
        .advance  (advance),
        .flush    (flush),
        .src_a    (src_a),
        .src_b    (src_b),
        .dst_sel  (dst_sel),
        .hazard_a (hazard_a),
        .hazard_b (hazard_b),
        .stall    (stall),
`ifdef REGDST_FWD_EN
        .fwd_a    (fwd_a),
        .fwd_b    (fwd_b),
`endif
        .ret_dst  (ret_dst),
        .ret_valid(ret_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  dst;
        int unsigned due;
    } sb_t;

    sb_t         sb[$];
    int          n_err = 0;
    int          n_checks = 0;
    int unsigned adv_cnt = 0;
    logic        exp_rv = 1'b0;
    logic [4:0]  exp_rd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge; acc says whether the bench expects the presented issue to be taken
    task automatic tick(input bit acc, input logic [4:0] d);
        sb_t e;
        if (acc && !flush && advance) begin
            e.dst = d;
            e.due = adv_cnt + DEPTH + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        if (flush) begin
            sb.delete();
            exp_rv = 1'b0;
        end else if (advance) begin
            adv_cnt++;
            if (sb.size() > 0 && sb[0].due == adv_cnt) begin
                exp_rv = 1'b1;
                exp_rd = sb[0].dst;
                void'(sb.pop_front());
            end else begin
                exp_rv = 1'b0;
            end
        end
        #1;
        chk("ret_valid", 32'(ret_valid), 32'(exp_rv));
        if (exp_rv) chk("ret_dst", 32'(ret_dst), 32'(exp_rd));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        issue = 1'b0;
        wr_en = 1'b0;
        src_a = '0;
        src_b = '0;
        for (int i = 0; i < n; i++) tick(1'b0, 5'd0);
    endtask

    initial begin
        int sel_tab[6];
        int exp_tab[6];
        sel_tab = '{0, 1, 2, 3, 4, 6};
        exp_tab = '{8, 9, 29, 31, 10, 8};

        // Reset state
        src_a = 5'd12;
        src_b = 5'd12;
        #23;
        chk("reset_ret_valid", 32'(ret_valid), 32'd0);
        chk("reset_ret_dst", 32'(ret_dst), 32'd0);
        chk("reset_hazard_a", 32'(hazard_a), 32'd0);
        src_a = '0;
        src_b = '0;

        // Destination decode
        f20_16 = 5'd8;
        f15_11 = 5'd9;
        f25_21 = 5'd10;
        for (int i = 0; i < 6; i++) begin
            sel = 3'(sel_tab[i]);
            #1;
            chk($sformatf("decode_sel%0d", sel_tab[i]), 32'(dst_sel), 32'(exp_tab[i]));
        end

        @(negedge clk);
        reset_n = 1'b1;
        advance = 1'b1;

        // Latency and hazard: dst 12 issued, then younger issue reading it
        issue = 1'b1; wr_en = 1'b1; sel = 3'd1; f15_11 = 5'd12;
        tick(1'b1, 5'd12);
        issue = 1'b0;
        tick(1'b0, 5'd0);
        issue = 1'b1; wr_en = 1'b1; sel = 3'd0; f20_16 = 5'd5; src_a = 5'd12; src_b = 5'd3;
        #1;
        chk("hz_a_stage1", 32'(hazard_a), 32'd1);
        chk("hz_b_stage1", 32'(hazard_b), 32'd0);
        chk("stall_stage1", 32'(stall), FWD ? 32'd0 : 32'd1);
`ifdef REGDST_FWD_EN
        chk("fwd_a_stage1", 32'(fwd_a), 32'd2);
`endif
        tick(FWD, 5'd5);
        // r0 destination and r0 source never hazard; 12 now in stage 2
        f20_16 = 5'd0; src_a = 5'd0; src_b = 5'd12;
        #1;
        chk("hz_a_r0", 32'(hazard_a), 32'd0);
        chk("hz_b_stage2", 32'(hazard_b), 32'd1);
        chk("stall_stage2", 32'(stall), FWD ? 32'd0 : 32'd1);
        tick(1'b0, 5'd0);
        idle(DEPTH + 2);

        // Hold with advance low keeps the retired value
        issue = 1'b1; wr_en = 1'b1; sel = 3'd1; f15_11 = 5'd20;
        tick(1'b1, 5'd20);
        idle(3);
        advance = 1'b0;
        idle(3);
        advance = 1'b1;
        idle(2);

        // Flush with a same-edge issue
        issue = 1'b1; wr_en = 1'b1; sel = 3'd1; f15_11 = 5'd21;
        tick(1'b1, 5'd21);
        idle(2);
        src_a = 5'd21;
        #1;
        chk("hz_pre_flush", 32'(hazard_a), 32'd1);
        flush = 1'b1; issue = 1'b1; wr_en = 1'b1; f15_11 = 5'd22; src_a = '0;
        tick(1'b1, 5'd22);
        flush = 1'b0; issue = 1'b0;
        src_a = 5'd21; src_b = 5'd22;
        #1;
        chk("hz_a_post_flush", 32'(hazard_a), 32'd0);
        chk("hz_b_dropped", 32'(hazard_b), 32'd0);
        idle(DEPTH + 1);

`ifdef REGDST_FWD_EN
        // Forwarding: 7 only in stage 2, then 7 in stages 0 and 2
        issue = 1'b1; wr_en = 1'b1; sel = 3'd1; f15_11 = 5'd7;
        tick(1'b1, 5'd7);
        idle(2);
        issue = 1'b1; wr_en = 1'b0; src_b = 5'd7;
        #1;
        chk("fwd_b_stage2", 32'(fwd_b), 32'd3);
        chk("stall_fwd_stage2", 32'(stall), 32'd0);
        idle(DEPTH + 1);
        issue = 1'b1; wr_en = 1'b1; f15_11 = 5'd7;
        tick(1'b1, 5'd7);
        idle(1);
        issue = 1'b1; wr_en = 1'b1;
        tick(1'b1, 5'd7);
        issue = 1'b1; wr_en = 1'b0; src_b = 5'd7;
        #1;
        chk("fwd_b_stage0", 32'(fwd_b), 32'd1);
        chk("stall_fwd_stage0", 32'(stall), 32'd1);
        idle(DEPTH + 2);
`endif

        // Asynchronous reset with the pipeline full
        issue = 1'b1; wr_en = 1'b1; sel = 3'd1;
        f15_11 = 5'd1; tick(1'b1, 5'd1);
        f15_11 = 5'd2; tick(1'b1, 5'd2);
        f15_11 = 5'd3; tick(1'b1, 5'd3);
        idle(1);
        src_a = 5'd3;
        #1;
        chk("hz_pre_reset", 32'(hazard_a), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_ret_valid", 32'(ret_valid), 32'd0);
        chk("async_ret_dst", 32'(ret_dst), 32'd0);
        chk("async_hazard", 32'(hazard_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
